// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing generator for a VGA output. It walks a pixel position (sx, sy)
// across the whole raster, including the blanking intervals, and decodes the
// sync pins and helper strobes from that position. Every output is registered
// and describes the same pixel in the same cycle. The decodes are taken from
// the next-state counter values, so they line up with sx/sy and drawing logic
// downstream can use them with no realignment.
//
// Ports
//   pix_clk          in   pixel clock, the only clock
//   rst_n            in   asynchronous active-low reset
//   pix_en           in   advance enable; when low every register holds
//   sx               out  horizontal position, 0 .. H_WHOLE_LINE-1
//   sy               out  vertical position, 0 .. V_WHOLE_LINE-1
//   display_enabled  out  high inside the visible area
//   hsync            out  horizontal sync, active level H_SYNC_POL
//   vsync            out  vertical sync, active level V_SYNC_POL
//   line_start       out  high while sx == 0
//   frame_start      out  high while sx == 0 and sy == 0
//   frame_count      out  completed-frame counter, wraps
// -----------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int H_VISIBLE_AREA  = 640,
   parameter int H_FRONT_PORCH   = 16,
   parameter int H_SYNC_PULSE    = 96,
   parameter int H_BACK_PORCH    = 48,
   parameter int V_VISIBLE_AREA  = 480,
   parameter int V_FRONT_PORCH   = 10,
   parameter int V_SYNC_PULSE    = 2,
   parameter int V_BACK_PORCH    = 33,
   parameter int H_SYNC_POL      = 0,
   parameter int V_SYNC_POL      = 0,
   parameter int FRAME_CNT_WIDTH = 8,
   localparam int H_WHOLE_LINE   = H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH,
   localparam int V_WHOLE_LINE   = V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH,
   localparam int H_ADDR_WIDTH   = $clog2(H_WHOLE_LINE),
   localparam int V_ADDR_WIDTH   = $clog2(V_WHOLE_LINE)
) (
   input  logic                       pix_clk,
   input  logic                       rst_n,
   input  logic                       pix_en,
   output logic [H_ADDR_WIDTH-1:0]    sx,
   output logic [V_ADDR_WIDTH-1:0]    sy,
   output logic                       display_enabled,
   output logic                       hsync,
   output logic                       vsync,
   output logic                       line_start,
   output logic                       frame_start,
   output logic [FRAME_CNT_WIDTH-1:0] frame_count
);

   localparam logic [H_ADDR_WIDTH-1:0] H_LAST = H_ADDR_WIDTH'(H_WHOLE_LINE - 1);
   localparam logic [V_ADDR_WIDTH-1:0] V_LAST = V_ADDR_WIDTH'(V_WHOLE_LINE - 1);

   // Sync windows as half-open ranges [start, end)
   localparam int H_HS_START = H_VISIBLE_AREA + H_FRONT_PORCH;
   localparam int H_HS_END   = H_HS_START + H_SYNC_PULSE;
   localparam int V_VS_START = V_VISIBLE_AREA + V_FRONT_PORCH;
   localparam int V_VS_END   = V_VS_START + V_SYNC_PULSE;

   localparam logic H_ACT = (H_SYNC_POL != 0);
   localparam logic V_ACT = (V_SYNC_POL != 0);

   logic                       started_q, started_d;
   logic [H_ADDR_WIDTH-1:0]    sx_q, sx_d;
   logic [V_ADDR_WIDTH-1:0]    sy_q, sy_d;
   logic                       de_q, de_d;
   logic                       hsync_q, hsync_d;
   logic                       vsync_q, vsync_d;
   logic                       line_start_q, line_start_d;
   logic                       frame_start_q, frame_start_d;
   logic [FRAME_CNT_WIDTH-1:0] frame_count_q, frame_count_d;

   // Zero-extended copies so range checks against the integer parameters
   // never truncate a bound that happens to equal the whole-line length.
   logic [31:0] sx_ext;
   logic [31:0] sy_ext;
   logic        h_active;
   logic        v_active;

   // Next position. Before the first enabled edge the counters present the
   // origin, and that first presentation of (0,0) is not a completed frame.
   always_comb begin
      started_d     = 1'b1;
      sx_d          = '0;
      sy_d          = '0;
      frame_count_d = frame_count_q;
      if (started_q) begin
         if (sx_q == H_LAST) begin
            sx_d = '0;
            sy_d = (sy_q == V_LAST) ? '0 : sy_q + V_ADDR_WIDTH'(1);
         end else begin
            sx_d = sx_q + H_ADDR_WIDTH'(1);
            sy_d = sy_q;
         end
         if ((sx_d == '0) && (sy_d == '0)) begin
            frame_count_d = frame_count_q + FRAME_CNT_WIDTH'(1);
         end
      end
   end

   // Decodes from the next-state position so they land with that position.
   always_comb begin
      sx_ext        = 32'(sx_d);
      sy_ext        = 32'(sy_d);
      h_active      = (sx_ext >= H_HS_START) && (sx_ext < H_HS_END);
      v_active      = (sy_ext >= V_VS_START) && (sy_ext < V_VS_END);
      de_d          = (sx_ext < H_VISIBLE_AREA) && (sy_ext < V_VISIBLE_AREA);
      hsync_d       = h_active ? H_ACT : ~H_ACT;
      vsync_d       = v_active ? V_ACT : ~V_ACT;
      line_start_d  = (sx_d == '0);
      frame_start_d = (sx_d == '0) && (sy_d == '0);
   end

   always_ff @(posedge pix_clk or negedge rst_n) begin
      if (!rst_n) begin
         started_q     <= 1'b0;
         sx_q          <= '0;
         sy_q          <= '0;
         de_q          <= 1'b0;
         hsync_q       <= ~H_ACT;
         vsync_q       <= ~V_ACT;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         frame_count_q <= '0;
      end else if (pix_en) begin
         started_q     <= started_d;
         sx_q          <= sx_d;
         sy_q          <= sy_d;
         de_q          <= de_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign sx              = sx_q;
   assign sy              = sy_q;
   assign display_enabled = de_q;
   assign hsync           = hsync_q;
   assign vsync           = vsync_q;
   assign line_start      = line_start_q;
   assign frame_start     = frame_start_q;
   assign frame_count     = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Two instances share one clock: dut_a with default 640x480 timing, driven
// from a table of {inputs, cycles, expected outputs}, and dut_b with a tiny
// raster (15 x 11, active-high hsync, 2-bit frame counter) used for whole-
// frame checks and a randomized run against a position-count reference model.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- dut_a : default timing ----------------
   logic       rst_a, en_a;
   logic [9:0] sx_a, sy_a;
   logic       de_a, hs_a, vs_a, ls_a, fs_a;
   logic [7:0] fc_a;

   vga_timing_gen dut_a (
      .pix_clk(clk), .rst_n(rst_a), .pix_en(en_a),
      .sx(sx_a), .sy(sy_a), .display_enabled(de_a),
      .hsync(hs_a), .vsync(vs_a), .line_start(ls_a),
      .frame_start(fs_a), .frame_count(fc_a)
   );

   // ---------------- dut_b : small raster ----------------
   localparam int BHV = 8, BHF = 2, BHS = 3, BHB = 2;
   localparam int BVV = 6, BVF = 1, BVS = 2, BVB = 2;
   localparam int BHW = BHV + BHF + BHS + BHB;   // 15
   localparam int BVW = BVV + BVF + BVS + BVB;   // 11
   localparam int BFRAME = BHW * BVW;            // 165

   logic       rst_b, en_b;
   logic [3:0] sx_b, sy_b;
   logic       de_b, hs_b, vs_b, ls_b, fs_b;
   logic [1:0] fc_b;

   vga_timing_gen #(
      .H_VISIBLE_AREA(BHV), .H_FRONT_PORCH(BHF), .H_SYNC_PULSE(BHS), .H_BACK_PORCH(BHB),
      .V_VISIBLE_AREA(BVV), .V_FRONT_PORCH(BVF), .V_SYNC_PULSE(BVS), .V_BACK_PORCH(BVB),
      .H_SYNC_POL(1), .V_SYNC_POL(0), .FRAME_CNT_WIDTH(2)
   ) dut_b (
      .pix_clk(clk), .rst_n(rst_b), .pix_en(en_b),
      .sx(sx_b), .sy(sy_b), .display_enabled(de_b),
      .hsync(hs_b), .vsync(vs_b), .line_start(ls_b),
      .frame_start(fs_b), .frame_count(fc_b)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic rst_n;
      logic en;
      int   n;
      int   sx;
      int   sy;
      logic de;
      logic hs;
      logic vs;
      logic ls;
      logic fs;
      int   fc;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, input logic e, input int n,
                               input int esx, input int esy,
                               input logic ede, input logic ehs, input logic evs,
                               input logic els, input logic efs, input int efc);
      vec_t v;
      v.rst_n = r;  v.en = e;  v.n = n;
      v.sx = esx;   v.sy = esy;
      v.de = ede;   v.hs = ehs; v.vs = evs; v.ls = els; v.fs = efs;
      v.fc = efc;
      return v;
   endfunction

   task automatic chk_a(input string tag, input int esx, input int esy,
                        input logic ede, input logic ehs, input logic evs,
                        input logic els, input logic efs, input int efc);
      checks++;
      if (sx_a !== 10'(esx) || sy_a !== 10'(esy) || de_a !== ede || hs_a !== ehs ||
          vs_a !== evs || ls_a !== els || fs_a !== efs || fc_a !== 8'(efc)) begin
         failures++;
         $display("FAIL %s: got sx=%0d sy=%0d de=%b hs=%b vs=%b ls=%b fs=%b fc=%0d, want sx=%0d sy=%0d de=%b hs=%b vs=%b ls=%b fs=%b fc=%0d",
                  tag, sx_a, sy_a, de_a, hs_a, vs_a, ls_a, fs_a, fc_a,
                  esx, esy, ede, ehs, evs, els, efs, efc);
      end else begin
         $display("ok   %s: sx=%0d sy=%0d de=%b hs=%b vs=%b ls=%b fs=%b fc=%0d",
                  tag, sx_a, sy_a, de_a, hs_a, vs_a, ls_a, fs_a, fc_a);
      end
   endtask

   // Reference model for dut_b: a count of enabled edges since start-up.
   // Position, decodes and frame count all follow from that count.
   bit mb_started = 1'b0;
   int mb_t       = 0;

   task automatic model_b_edge();
      if (!rst_b) begin
         mb_started = 1'b0;
         mb_t       = 0;
      end else if (en_b) begin
         if (!mb_started) begin
            mb_started = 1'b1;
            mb_t       = 0;
         end else begin
            mb_t++;
         end
      end
   endtask

   task automatic chk_b_model(input string tag);
      int   esx, esy, efc;
      logic ede, ehs, evs, els, efs;
      if (!mb_started) begin
         esx = 0; esy = 0; efc = 0;
         ede = 1'b0; ehs = 1'b0; evs = 1'b1; els = 1'b0; efs = 1'b0;
      end else begin
         esx = mb_t % BHW;
         esy = (mb_t / BHW) % BVW;
         efc = (mb_t / BFRAME) % 4;
         ede = (esx < BHV) && (esy < BVV);
         ehs = (esx >= BHV + BHF) && (esx < BHV + BHF + BHS);
         evs = !((esy >= BVV + BVF) && (esy < BVV + BVF + BVS));
         els = (esx == 0);
         efs = (esx == 0) && (esy == 0);
      end
      checks++;
      if (sx_b !== 4'(esx) || sy_b !== 4'(esy) || de_b !== ede || hs_b !== ehs ||
          vs_b !== evs || ls_b !== els || fs_b !== efs || fc_b !== 2'(efc)) begin
         failures++;
         $display("FAIL %s: got sx=%0d sy=%0d de=%b hs=%b vs=%b ls=%b fs=%b fc=%0d, want sx=%0d sy=%0d de=%b hs=%b vs=%b ls=%b fs=%b fc=%0d",
                  tag, sx_b, sy_b, de_b, hs_b, vs_b, ls_b, fs_b, fc_b,
                  esx, esy, ede, ehs, evs, els, efs, efc);
      end
   endtask

   task automatic chk_int(input string tag, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s: got %0d, want %0d", tag, got, want);
      end else begin
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   initial begin
      int fc_seen[$];
      int fs_cyc[$];
      int cyc, vs_low, hs_high;

      rst_a = 1'b0; en_a = 1'b0;
      rst_b = 1'b0; en_b = 1'b0;

      // ------------- dut_a table: {rst_n, en, edges, expected} -------------
      //                r     e     n    sx   sy  de    hs    vs    ls    fs    fc
      vecs.push_back(mk(1'b0, 1'b1, 5,   0,   0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0)); // in reset
      vecs.push_back(mk(1'b1, 1'b0, 3,   0,   0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0)); // released, not enabled
      vecs.push_back(mk(1'b1, 1'b1, 1,   0,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0)); // start-up edge
      vecs.push_back(mk(1'b1, 1'b1, 1,   1,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0));
      vecs.push_back(mk(1'b1, 1'b1, 638, 639, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0)); // last visible
      vecs.push_back(mk(1'b1, 1'b1, 1,   640, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0)); // blanking starts
      vecs.push_back(mk(1'b1, 1'b1, 15,  655, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0)); // just before sync
      vecs.push_back(mk(1'b1, 1'b0, 7,   655, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0)); // frozen
      vecs.push_back(mk(1'b1, 1'b1, 1,   656, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0)); // sync starts
      vecs.push_back(mk(1'b1, 1'b1, 95,  751, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0)); // last sync pixel
      vecs.push_back(mk(1'b1, 1'b1, 1,   752, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0)); // sync ends
      vecs.push_back(mk(1'b1, 1'b1, 47,  799, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0)); // end of line
      vecs.push_back(mk(1'b1, 1'b1, 1,   0,   1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0)); // line wrap
      vecs.push_back(mk(1'b1, 1'b0, 3,   0,   1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0)); // strobe held
      vecs.push_back(mk(1'b1, 1'b1, 1,   1,   1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0)); // strobe drops
      vecs.push_back(mk(1'b1, 1'b1, 299, 300, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0)); // mid-line

      foreach (vecs[i]) begin
         @(negedge clk);
         rst_a = vecs[i].rst_n;
         en_a  = vecs[i].en;
         repeat (vecs[i].n) @(posedge clk);
         #1;
         chk_a($sformatf("vec%0d", i), vecs[i].sx, vecs[i].sy, vecs[i].de, vecs[i].hs,
               vecs[i].vs, vecs[i].ls, vecs[i].fs, vecs[i].fc);
      end

      // Asynchronous reset between edges, then the start-up sequence again.
      @(negedge clk);
      rst_a = 1'b0;
      #1;
      chk_a("async_rst", 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      @(negedge clk);
      @(negedge clk);
      rst_a = 1'b1;
      en_a  = 1'b1;
      @(posedge clk); #1;
      chk_a("restart_edge", 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0);
      @(posedge clk); #1;
      chk_a("restart_next", 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      en_a = 1'b0;

      // ------------- dut_b: five frames with pix_en held high -------------
      @(negedge clk);
      rst_b = 1'b1;
      en_b  = 1'b1;
      cyc = 0; vs_low = 0; hs_high = 0;
      for (int c = 0; c < 5 * BFRAME + 20 && fc_seen.size() < 5; c++) begin
         @(posedge clk); #1;
         cyc++;
         if (fs_b === 1'b1) begin
            fc_seen.push_back(int'(fc_b));
            fs_cyc.push_back(cyc);
         end
         if (fc_seen.size() == 1) begin
            if (vs_b === 1'b0) vs_low++;
            if (hs_b === 1'b1) hs_high++;
         end
      end
      if (fc_seen.size() < 5) begin
         checks++;
         failures++;
         $display("FAIL frame_start_timeout: got %0d frame starts, want 5", fc_seen.size());
      end else begin
         chk_int("first_fs_cycle", fs_cyc[0], 1);
         for (int i = 0; i < 5; i++)
            chk_int($sformatf("frame_count_%0d", i), fc_seen[i], i % 4);
         for (int i = 1; i < 5; i++)
            chk_int($sformatf("frame_period_%0d", i), fs_cyc[i] - fs_cyc[i-1], BFRAME);
         chk_int("vsync_active_cycles", vs_low, BVS * BHW);
         chk_int("hsync_active_cycles", hs_high, BHS * BVW);
      end

      // ------------- dut_b: randomized pix_en and resets vs model -------------
      @(negedge clk);
      rst_b = 1'b0;
      en_b  = 1'b0;
      mb_started = 1'b0;
      mb_t       = 0;
      #1;
      chk_b_model("rnd_reset");
      @(negedge clk);
      rst_b = 1'b1;
      en_b  = 1'b1;
      for (int c = 0; c < 1500; c++) begin
         @(posedge clk);
         model_b_edge();
         @(negedge clk);
         chk_b_model($sformatf("rnd%0d", c));
         en_b = ($urandom_range(3) != 0);
         if (!rst_b) begin
            rst_b = ($urandom_range(2) == 0);
         end else if ($urandom_range(299) == 0) begin
            rst_b      = 1'b0;
            mb_started = 1'b0;
            mb_t       = 0;
            #1;
            chk_b_model($sformatf("rnd_async_rst%0d", c));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
